// File: rtl/iob_vga_pkg.sv
// rtl/iob_vga_pkg.sv - shared video timing geometry, types and helpers
package iob_vga_pkg;

    localparam int VGA640_H_SYNC = 96;
    localparam int VGA640_H_BP   = 48;
    localparam int VGA640_H_ACT  = 640;
    localparam int VGA640_H_FP   = 16;
    localparam int VGA640_V_SYNC = 2;
    localparam int VGA640_V_BP   = 33;
    localparam int VGA640_V_ACT  = 480;
    localparam int VGA640_V_FP   = 10;
    localparam int VGA640_H_POL  = 0;
    localparam int VGA640_V_POL  = 0;

    localparam int VGA800_H_SYNC = 128;
    localparam int VGA800_H_BP   = 88;
    localparam int VGA800_H_ACT  = 800;
    localparam int VGA800_H_FP   = 40;
    localparam int VGA800_V_SYNC = 4;
    localparam int VGA800_V_BP   = 23;
    localparam int VGA800_V_ACT  = 600;
    localparam int VGA800_V_FP   = 1;
    localparam int VGA800_H_POL  = 1;
    localparam int VGA800_V_POL  = 1;

    localparam int VGA_CW = 4;

    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic active;
    } vga_sync_t;

    // Never returns less than 1 so degenerate counters still have a bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) bits = i + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/iob_vga_tick_gen.sv
// rtl/iob_vga_tick_gen.sv - pixel tick divider, one-clk tick every DIV cycles
module iob_vga_tick_gen
    import iob_vga_pkg::*;
#(
    parameter int DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iob_vga_timing_gen.sv
// rtl/iob_vga_timing_gen.sv - parametrised VGA timing generator with 2-stage aligned outputs
module iob_vga_timing_gen
    import iob_vga_pkg::*;
#(
    parameter int DIV    = 3,
    parameter int H_SYNC = VGA640_H_SYNC,
    parameter int H_BP   = VGA640_H_BP,
    parameter int H_ACT  = VGA640_H_ACT,
    parameter int H_FP   = VGA640_H_FP,
    parameter int V_SYNC = VGA640_V_SYNC,
    parameter int V_BP   = VGA640_V_BP,
    parameter int V_ACT  = VGA640_V_ACT,
    parameter int V_FP   = VGA640_V_FP,
    parameter int H_POL  = VGA640_H_POL,
    parameter int V_POL  = VGA640_V_POL,
    parameter int CW     = VGA_CW,
    parameter int XY_W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3*CW-1:0] rgb,
    output logic            pixel_req,
    output logic [XY_W-1:0] pixel_x,
    output logic [XY_W-1:0] pixel_y,
    output logic            h_sync,
    output logic            v_sync,
    output logic            de,
    output logic [CW-1:0]   red,
    output logic [CW-1:0]   green,
    output logic [CW-1:0]   blue,
    output logic            frame_start,
    output logic            line_start
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int CNT_W = clog2((H_TOT > V_TOT) ? H_TOT : V_TOT);

    // Boundaries are inclusive "last" values so none can exceed the counter range.
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_SYNC + V_BP + V_ACT - 1);

    localparam logic      H_ON   = (H_POL != 0);
    localparam logic      V_ON   = (V_POL != 0);
    localparam vga_sync_t S_IDLE = '{h_sync: !H_ON, v_sync: !V_ON, active: 1'b0};

    logic             tick;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             act0;
    logic [CNT_W-1:0] x_off;
    logic [CNT_W-1:0] y_off;
    vga_sync_t        s0;
    vga_sync_t        s1;

    iob_vga_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc <= '0;
            vc <= '0;
        end else if (!en) begin
            hc <= '0;
            vc <= '0;
        end else if (tick) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + CNT_W'(1);
            end else begin
                hc <= hc + CNT_W'(1);
            end
        end
    end

    always_comb begin
        act0      = (hc >= H_ACT_BEG) && (hc <= H_ACT_LAST) &&
                    (vc >= V_ACT_BEG) && (vc <= V_ACT_LAST);
        x_off     = hc - H_ACT_BEG;
        y_off     = vc - V_ACT_BEG;
        s0.h_sync = (hc < H_SYNC_END) ? H_ON : !H_ON;
        s0.v_sync = (vc < V_SYNC_END) ? V_ON : !V_ON;
        s0.active = act0;
    end

    // Stage 1: decoded position; pulses live for exactly the clk after a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1          <= S_IDLE;
            pixel_req   <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (!en) begin
            s1          <= S_IDLE;
            pixel_req   <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            pixel_req   <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            if (tick) begin
                s1          <= s0;
                pixel_req   <= act0;
                line_start  <= (hc == '0);
                frame_start <= (hc == '0) && (vc == '0);
                if (act0) begin
                    pixel_x <= XY_W'(x_off);
                    pixel_y <= XY_W'(y_off);
                end
            end
        end
    end

    // Stage 2: rgb arrives one tick after pixel_req; syncs are delayed to match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_sync              <= !H_ON;
            v_sync              <= !V_ON;
            de                  <= 1'b0;
            {red, green, blue}  <= '0;
        end else if (!en) begin
            h_sync              <= !H_ON;
            v_sync              <= !V_ON;
            de                  <= 1'b0;
            {red, green, blue}  <= '0;
        end else if (tick) begin
            h_sync              <= s1.h_sync;
            v_sync              <= s1.v_sync;
            de                  <= s1.active;
            {red, green, blue}  <= s1.active ? rgb : '0;
        end
    end

endmodule

// File: tb/tb_iob_vga_timing_gen.sv
// tb/tb_iob_vga_timing_gen.sv - directed self-checking bench for iob_vga_timing_gen
module tb_iob_vga_timing_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] a_rgb;
    logic [11:0] b_rgb;

    logic       a_req, a_hs, a_vs, a_de, a_fs, a_ls;
    logic [9:0] a_px, a_py;
    logic [3:0] a_r, a_g, a_b;
    logic       b_req, b_hs, b_vs, b_de, b_fs, b_ls;
    logic [9:0] b_px, b_py;
    logic [3:0] b_r, b_g, b_b;

    int checks = 0;
    int errors = 0;
    bit mon_on = 0;
    logic prev_req = 1'b0;
    logic [11:0] exp_q[$];

    iob_vga_timing_gen #(
        .DIV(1), .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
        .H_POL(0), .V_POL(0), .CW(4), .XY_W(10)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .rgb(a_rgb),
        .pixel_req(a_req), .pixel_x(a_px), .pixel_y(a_py),
        .h_sync(a_hs), .v_sync(a_vs), .de(a_de),
        .red(a_r), .green(a_g), .blue(a_b),
        .frame_start(a_fs), .line_start(a_ls)
    );

    iob_vga_timing_gen #(
        .DIV(2), .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
        .H_POL(1), .V_POL(1), .CW(4), .XY_W(10)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .rgb(b_rgb),
        .pixel_req(b_req), .pixel_x(b_px), .pixel_y(b_py),
        .h_sync(b_hs), .v_sync(b_vs), .de(b_de),
        .red(b_r), .green(b_g), .blue(b_b),
        .frame_start(b_fs), .line_start(b_ls)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Instance A: answer each pixel_req with data encoding its coordinates, and
    // verify that exactly that data reaches the pins one clk later, blank otherwise.
    initial begin
        logic [11:0] want;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                check("a_de_after_req", 32'(a_de), 32'(prev_req));
                if (a_de) begin
                    if (exp_q.size() == 0) begin
                        check("a_rgb_queue_empty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        want = exp_q.pop_front();
                        check("a_rgb_active", 32'({a_r, a_g, a_b}), 32'(want));
                    end
                end else begin
                    check("a_rgb_blank", 32'({a_r, a_g, a_b}), 32'd0);
                end
                if (a_req) exp_q.push_back({a_px[3:0], a_py[3:0], 4'hC});
            end
            a_rgb    = a_req ? {a_px[3:0], a_py[3:0], 4'hC} : 12'hFFF;
            prev_req = a_req;
        end
    end

    initial begin
        int a_nfs, b_nfs, a_fs1, a_fs2, b_fs1, b_fs2;
        int a_ls_cnt, a_de_cnt, a_hs_lo, a_vs_lo, a_reqs;
        int b_de_cnt, b_hs_hi, b_vs_hi, b_reqs, b_col_bad, fs_no_ls, strobes;
        bit found;

        rst   = 1'b0;
        en    = 1'b0;
        a_rgb = 12'hFFF;
        b_rgb = 12'hABC;
        repeat (3) @(negedge clk);

        check("rst_a_hsync", 32'(a_hs), 32'd1);
        check("rst_a_vsync", 32'(a_vs), 32'd1);
        check("rst_b_hsync", 32'(b_hs), 32'd0);
        check("rst_b_vsync", 32'(b_vs), 32'd0);
        check("rst_a_outs", 32'({a_de, a_req, a_fs, a_ls, a_r, a_g, a_b}), 32'd0);
        check("rst_a_xy", 32'({a_px, a_py}), 32'd0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("en_low_idle", 32'({a_de, a_req, a_fs, b_de, b_req, b_fs}), 32'd0);

        // Frame measurement: A ticks every clk (60 clk/frame), B every 2 clk (120 clk/frame).
        exp_q.delete();
        mon_on = 1;
        en     = 1'b1;
        a_nfs = 0; b_nfs = 0; a_fs1 = -1; a_fs2 = -1; b_fs1 = -1; b_fs2 = -1;
        a_ls_cnt = 0; a_de_cnt = 0; a_hs_lo = 0; a_vs_lo = 0; a_reqs = 0;
        b_de_cnt = 0; b_hs_hi = 0; b_vs_hi = 0; b_reqs = 0; b_col_bad = 0; fs_no_ls = 0;
        for (int k = 1; k <= 400 && (a_nfs < 2 || b_nfs < 2); k++) begin
            @(negedge clk);
            if ((a_fs && !a_ls) || (b_fs && !b_ls)) fs_no_ls++;
            if (a_fs && a_nfs < 2) begin
                a_nfs++;
                if (a_nfs == 1) a_fs1 = k;
                else begin
                    a_fs2 = k;
                    check("a_px_hold", 32'(a_px), 32'd3);
                    check("a_py_hold", 32'(a_py), 32'd2);
                end
            end
            if (b_fs && b_nfs < 2) begin
                b_nfs++;
                if (b_nfs == 1) b_fs1 = k; else b_fs2 = k;
            end
            if (a_nfs == 1) begin
                a_ls_cnt += int'(a_ls);
                a_de_cnt += int'(a_de);
                a_hs_lo  += int'(!a_hs);
                a_vs_lo  += int'(!a_vs);
                if (a_req) begin
                    check("a_pixel_x", 32'(a_px), 32'(a_reqs % 4));
                    check("a_pixel_y", 32'(a_py), 32'(a_reqs / 4));
                    a_reqs++;
                end
            end
            if (b_nfs == 1) begin
                b_de_cnt += int'(b_de);
                b_hs_hi  += int'(b_hs);
                b_vs_hi  += int'(b_vs);
                b_reqs   += int'(b_req);
                if (b_de ? ({b_r, b_g, b_b} != 12'hABC) : ({b_r, b_g, b_b} != 12'h000))
                    b_col_bad++;
            end
        end
        check("a_first_fs_clk", 32'(a_fs1), 32'd1);
        check("a_second_fs_clk", 32'(a_fs2), 32'd61);
        check("b_first_fs_clk", 32'(b_fs1), 32'd2);
        check("b_second_fs_clk", 32'(b_fs2), 32'd122);
        check("a_lines_per_frame", 32'(a_ls_cnt), 32'd6);
        check("a_de_clks", 32'(a_de_cnt), 32'd12);
        check("a_hsync_low_clks", 32'(a_hs_lo), 32'd12);
        check("a_vsync_low_clks", 32'(a_vs_lo), 32'd10);
        check("a_reqs_per_frame", 32'(a_reqs), 32'd12);
        check("b_de_clks", 32'(b_de_cnt), 32'd24);
        check("b_hsync_high_clks", 32'(b_hs_hi), 32'd24);
        check("b_vsync_high_clks", 32'(b_vs_hi), 32'd20);
        check("b_reqs_per_frame", 32'(b_reqs), 32'd12);
        check("b_colour_abc", 32'(b_col_bad), 32'd0);
        check("fs_implies_ls", 32'(fs_no_ls), 32'd0);

        // Drop en mid-active at A pixel (2,1), then restart.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (a_req && a_px == 10'd2 && a_py == 10'd1) found = 1;
        end
        check("find_mid_active", 32'(found), 32'd1);
        mon_on = 0;
        en     = 1'b0;
        @(negedge clk);
        check("drop_a_blank", 32'({a_de, a_req, a_fs, a_ls, a_r, a_g, a_b}), 32'd0);
        check("drop_a_syncs", 32'({a_hs, a_vs}), 32'd3);
        check("drop_b_syncs", 32'({b_hs, b_vs, b_de}), 32'd0);
        check("drop_a_xy", 32'({a_px, a_py}), 32'd0);
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            strobes += int'(a_fs) + int'(a_ls) + int'(a_req) + int'(b_fs) + int'(b_ls) + int'(b_req);
        end
        check("drop_no_strobes", 32'(strobes), 32'd0);
        exp_q.delete();
        mon_on = 1;
        en     = 1'b1;
        @(negedge clk);
        check("restart_a_fs", 32'({a_fs, a_ls}), 32'd3);
        check("restart_b_wait", 32'(b_fs), 32'd0);
        @(negedge clk);
        check("restart_b_fs", 32'({b_fs, b_ls}), 32'd3);
        repeat (70) @(negedge clk);

        // Asynchronous reset between clock edges while A is displaying.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (a_de) found = 1;
        end
        check("find_de_for_reset", 32'(found), 32'd1);
        mon_on = 0;
        #1 rst = 1'b0;
        #1;
        check("arst_a_outs", 32'({a_de, a_req, a_fs, a_ls, a_r, a_g, a_b}), 32'd0);
        check("arst_a_syncs", 32'({a_hs, a_vs}), 32'd3);
        check("arst_b_syncs", 32'({b_hs, b_vs}), 32'd0);
        check("arst_a_xy", 32'({a_px, a_py}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
